periph_rr_arbiter: RTL

- Shares one send/ack peripheral, with a 16-bit data input and a four-phase handshake, among N_REQ requesters.
- Arbitrates round-robin and latches the winner's data.
- Drives the peripheral's send/data, waits for ack to rise and then fall, and returns a one-cycle done pulse to the winner.
- Sits between bus masters and the peripheral FSM; it is the only driver of the peripheral's send and data inputs.

---
 rtl/periph_arb_pkg.sv | 15 +
 rtl/periph_rr_arbiter_rr_pick.sv | 50 +++++
 rtl/periph_rr_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/periph_arb_pkg.sv
// Shared types and default constants for the round-robin peripheral arbiter.
// Optional watchdog is enabled by defining PERIPH_ARB_TIMEOUT_EN.
package periph_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } arb_state_e;

    localparam int DEFAULT_DATA_W         = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/periph_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate the request vector by ptr,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    logic [N_REQ-1:0] rot;
    logic [PTR_W-1:0] rot_idx;
    logic [PTR_W:0]   sum;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [PTR_W:0] src;
            always_comb begin
                src = (PTR_W+1)'(gi) + {1'b0, ptr};
                if (src >= (PTR_W+1)'(N_REQ)) begin
                    src = src - (PTR_W+1)'(N_REQ);
                end
            end
            assign rot[gi] = req[src[PTR_W-1:0]];
        end
    endgenerate

    // Scan downwards so the lowest rotated index (closest to ptr) wins.
    always_comb begin
        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, rot_idx} + {1'b0, ptr};
        if (sum >= (PTR_W+1)'(N_REQ)) begin
            sum = sum - (PTR_W+1)'(N_REQ);
        end
        winner = sum[PTR_W-1:0];
    end

    assign any_req = |req;

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin arbiter sharing one send/ack (four-phase) peripheral among N_REQ masters.
// Define PERIPH_ARB_TIMEOUT_EN to add a per-phase watchdog that aborts with err.
module periph_rr_arbiter
    import periph_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic                    err,
    output logic                    busy,
    output logic                    periph_send,
    output logic [DATA_W-1:0]       periph_data,
    input  logic                    periph_ack
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d, winner_q, winner_d, pick;
    logic [N_REQ-1:0]  grant_q, grant_d, done_q, done_d;
    logic              send_q, send_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              any_req, timeout_hit, abort;

    rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (pick),
        .any_req (any_req)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        grant_d  = grant_q;
        done_d   = '0;
        send_d   = send_q;
        data_d   = data_q;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = SEND;
                    winner_d = pick;
                    grant_d  = N_REQ'(1) << pick;
                    data_d   = req_data[pick*DATA_W +: DATA_W];
                    send_d   = 1'b1;
                end
            end
            SEND: begin
                if (periph_ack) begin
                    send_d  = 1'b0;
                    state_d = RELEASE;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            RELEASE: begin
                if (!periph_ack) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                data_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = DONE;
            send_d  = 1'b0;
        end
        // Normal completion and watchdog abort retire the transaction identically.
        if (state_d == DONE && state_q != DONE) begin
            done_d  = grant_q;
            grant_d = '0;
            ptr_d   = (winner_q == PTR_W'(N_REQ - 1)) ? '0 : winner_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            winner_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            send_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            send_q   <= send_d;
            data_q   <= data_d;
        end
    end

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state entry, so each handshake phase gets its own budget.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && (state_q == SEND || state_q == RELEASE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= abort;
        end
    end

    assign err = err_q;
`else
    // No watchdog: a positive limit never fires, so ack is awaited indefinitely.
    assign timeout_hit = (TIMEOUT_CYCLES < 1);
    assign err         = 1'b0;
`endif

    assign grant       = grant_q;
    assign done        = done_q;
    assign periph_send = send_q;
    assign periph_data = data_q;
    assign busy        = (state_q != IDLE);

endmodule
